led_pattern_decoder: RTL and testbench
======================================

# led_pattern_decoder

Observes the 4-bit one-hot LED bus driven by the LED chaser and decodes it back into the chaser's pattern ID and step index. It sits beside the chaser on the same clock as a self-check / monitor block. It locks onto the running pattern (back-and-forth, left, right) and flags any LED transition or stall that breaks the locked sequence, keeping a saturating error count.

## Interface

Parameters:
- TIMEOUT, default 25'd16777216: cycles without an LED change before a stall is declared. The default is 2× the chaser step period of 2^23.
- TW, default 25: width of the stall timer. TIMEOUT must fit in TW bits.

Ports:
- CLK  input  1  system clock. All logic is on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- LED  input  4  LED bus from the chaser, synchronous to CLK.
- CLR  input  1  synchronous clear of ERR_CNT.
- PATTERN  output  2  0 = back-and-forth, 1 = left, 2 = right, 3 = not locked.
- STEP  output  3  step index in the locked pattern; 0 when not locked.
- LOCKED  output  1  high while in LOCK.
- STEP_STB  output  1  one-cycle pulse on every accepted transition, including lock entry.
- ERR  output  1  one-cycle pulse on sequence violation or stall while locked.
- ERR_CNT  output  8  saturating error count.

## Operation

Input staging:
- LED_s captures LED every cycle. LED_p holds the previous LED_s.
- A "change" is LED_s != LED_p.
- A value is "valid" when LED_s is one-hot. Its position q is 0..3, with bit0 = 0.

Stall timer:
- Cleared on every change, otherwise increments and saturates at TIMEOUT.
- Held at 0 in EMPTY.

States (p is the stored position; d is the direction, up = +1, down = -1):
- EMPTY: on a valid LED_s, go to ACQ with p = q. Invalid input stays in EMPTY without error.
- ACQ, on a change:
  - Invalid → EMPTY.
  - q = p±1 → DIR, with d set to the sign of the step.
  - p=3, q=0 → LOCK as left.
  - p=0, q=3 → LOCK as right.
  - |q−p| = 2 → stay in ACQ with p = q.
- DIR, on a change:
  - q = p+d → stay in DIR, p = q.
  - Reversal at an end (p=3, d=up, q=2; or p=0, d=down, q=1) → LOCK as back-and-forth.
  - Wrap (p=3, d=up, q=0) → LOCK as left.
  - Wrap (p=0, d=down, q=3) → LOCK as right.
  - Any other valid value → ACQ with p = q.
  - Invalid → EMPTY.
- LOCK: each change is compared against the expected next position.
  - Match: advance STEP and pulse STEP_STB.
  - Mismatch: pulse ERR and increment ERR_CNT. If the new value is valid, go to ACQ with p = q; if invalid, go to EMPTY.

Step rules:
- Back-and-forth: STEP is 0..5, mapping to positions 0,1,2,3,2,1. Next step is (STEP+1) mod 6.
- Left: STEP = position. Next position is (pos+1) mod 4.
- Right: STEP = 3 − position. Next position is (pos−1) mod 4.

STEP at lock entry:
- Back-and-forth locked at the top reversal → 4.
- Back-and-forth locked at the bottom reversal → 1.
- Left → 0.
- Right → 0.

Stall handling:
- When the timer reaches TIMEOUT in ACQ or DIR: go to ACQ with p = current position, no error.
- When it reaches TIMEOUT in LOCK: pulse ERR, increment ERR_CNT, go to ACQ with p = current position.
- The timer restarts after a stall.

Outputs and counter:
- Whenever the state is not LOCK: PATTERN = 3, STEP = 0, LOCKED = 0.
- ERR_CNT saturates at 255.
- If CLR and an error occur in the same cycle, CLR wins: ERR_CNT becomes 0, but ERR still pulses.

## Timing

- Reset values: PATTERN = 3, STEP = 0, LOCKED = 0, STEP_STB = 0, ERR = 0, ERR_CNT = 0. Internally: state EMPTY, LED_s = LED_p = 0, timer = 0.
- Reset asserts asynchronously at any time, including mid-lock, and outputs take their reset values immediately. Release is synchronous to the next CLK edge.
- Latency: a LED value captured at edge n into LED_s is evaluated at edge n+1. Outputs, STEP_STB and ERR all reflect it after edge n+1, so there are 2 edges from LED to output.
- STEP_STB and ERR are single-cycle pulses and never both high in the same cycle.
- The next change after an error is evaluated against the new ACQ/EMPTY state, not the old lock.

## Test plan

Common setup: TIMEOUT = 16, LED changes every 4 cycles.

1. Left lock: LED 0001, 0010, 0100, 1000, 0001 → LOCKED = 1, PATTERN = 1, STEP = 0, STEP_STB pulses. Next 0010 → STEP = 1.
2. Back-and-forth lock: LED 0001, 0010, 0100, 1000, 0100 → PATTERN = 0, STEP = 4. Then 0010 → STEP = 5; then 0001 → STEP = 0. ERR stays 0 throughout.
3. Right lock: LED 1000, 0100, 0010, 0001, 1000 → PATTERN = 2, STEP = 0. Next 0100 → STEP = 1.
4. Jump violation: locked left at 0001, then LED = 0100 → ERR pulses once, ERR_CNT = 1, LOCKED = 0, PATTERN = 3. Then 1000, 0001 → relocks left.
5. Stall and clear: locked, LED held constant for 16 cycles → ERR pulses, ERR_CNT increments, LOCKED = 0. Repeat the stall with CLR high in the ERR cycle → ERR pulses, ERR_CNT = 0.
6. Invalid input and reset: locked, LED = 0011 → ERR, state EMPTY, no further errors while LED stays 0000. Then RST low mid-lock → all outputs at reset values without waiting for a clock edge. Force ERR_CNT to 255 with further errors → stays 255.

Source files
------------

// File: rtl/led_pattern_decoder_if.sv
// LED monitor bus: the chaser's LED lines and the clear input in, the decoded pattern/step,
// the lock status, the error strobes and the FSM debug state out.
interface led_pattern_decoder_if;
  // There is no handshake on this bus.
  // LED and CLR are sampled on every rising CLK edge.
  // STEP_STB and ERR are single-cycle strobes; there is no ready or backpressure.
  logic [3:0] LED;
  logic       CLR;
  logic [1:0] PATTERN;
  logic [2:0] STEP;
  logic       LOCKED;
  logic       STEP_STB;
  logic       ERR;
  logic [7:0] ERR_CNT;
  logic [1:0] DBG_STATE;

  modport master (
    output LED, CLR,
    input  PATTERN, STEP, LOCKED, STEP_STB, ERR, ERR_CNT, DBG_STATE
  );

  modport slave (
    input  LED, CLR,
    output PATTERN, STEP, LOCKED, STEP_STB, ERR, ERR_CNT, DBG_STATE
  );
endinterface

// File: rtl/led_pattern_decoder.sv
// Monitors the one-hot LED chaser bus and recovers its pattern and step index.
// Flags sequence breaks and stalls while locked, and keeps a saturating error count.
module led_pattern_decoder #(
  parameter int unsigned TIMEOUT = 25'd16777216,
  parameter int unsigned TW      = 25
) (
  input logic CLK,
  input logic RST,
  led_pattern_decoder_if.slave bus
);
  typedef enum logic [1:0] {S_EMPTY, S_ACQ, S_DIR, S_LOCK} state_t;

  localparam logic [TW-1:0] TMO       = TW'(TIMEOUT);
  localparam logic [1:0]    PAT_BF    = 2'd0;
  localparam logic [1:0]    PAT_LEFT  = 2'd1;
  localparam logic [1:0]    PAT_RIGHT = 2'd2;
  localparam logic [1:0]    PAT_NONE  = 2'd3;

  state_t        state_q, state_d;
  logic [3:0]    led_s, led_p;
  logic [1:0]    pos_q, pos_d, q, npos;
  logic          dir_up_q, dir_up_d;
  logic [1:0]    pat_q, pat_d;
  logic [2:0]    step_q, step_d, nstep;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          stb_q, stb_d, err_q, err_d;
  logic [7:0]    cnt_q;
  logic          change, valid, stall;

  function automatic logic [1:0] bf_pos(input logic [2:0] s);
    case (s)
      3'd4:    return 2'd2;
      3'd5:    return 2'd1;
      default: return s[1:0];
    endcase
  endfunction

  assign change = (led_s != led_p);
  assign valid  = $onehot(led_s);
  assign stall  = (tmr_q == TMO) && !change;

  always_comb begin
    case (led_s)
      4'b0010: q = 2'd1;
      4'b0100: q = 2'd2;
      4'b1000: q = 2'd3;
      default: q = 2'd0;
    endcase
  end

  // Expected next position and step for the locked pattern.
  always_comb begin
    npos  = pos_q;
    nstep = step_q;
    case (pat_q)
      PAT_LEFT: begin
        npos  = pos_q + 2'd1;
        nstep = {1'b0, npos};
      end
      PAT_RIGHT: begin
        npos  = pos_q - 2'd1;
        nstep = {1'b0, 2'd3 - npos};
      end
      default: begin
        nstep = (step_q == 3'd5) ? 3'd0 : step_q + 3'd1;
        npos  = bf_pos(nstep);
      end
    endcase
  end

  // The stall timer only runs while something has been acquired.
  always_comb begin
    if (state_q == S_EMPTY || change || tmr_q == TMO) tmr_d = '0;
    else                                              tmr_d = tmr_q + TW'(1);
  end

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    pat_d    = pat_q;
    step_d   = step_q;
    stb_d    = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_EMPTY: begin
        if (valid) begin
          state_d = S_ACQ;
          pos_d   = q;
        end
      end
      S_ACQ: begin
        if (change) begin
          pos_d = q;
          if (!valid) state_d = S_EMPTY;
          else if (pos_q == 2'd3 && q == 2'd0) begin
            state_d = S_LOCK; pat_d = PAT_LEFT; step_d = 3'd0; stb_d = 1'b1;
          end else if (pos_q == 2'd0 && q == 2'd3) begin
            state_d = S_LOCK; pat_d = PAT_RIGHT; step_d = 3'd0; stb_d = 1'b1;
          end else if (q == pos_q + 2'd1) begin
            state_d = S_DIR; dir_up_d = 1'b1;
          end else if (q == pos_q - 2'd1) begin
            state_d = S_DIR; dir_up_d = 1'b0;
          end
        end else if (stall) pos_d = q;
      end
      S_DIR: begin
        if (change) begin
          pos_d   = q;
          state_d = S_ACQ;
          if (!valid) state_d = S_EMPTY;
          else if (pos_q == 2'd3 && dir_up_q) begin
            if (q == 2'd2) begin
              state_d = S_LOCK; pat_d = PAT_BF; step_d = 3'd4; stb_d = 1'b1;
            end else if (q == 2'd0) begin
              state_d = S_LOCK; pat_d = PAT_LEFT; step_d = 3'd0; stb_d = 1'b1;
            end
          end else if (pos_q == 2'd0 && !dir_up_q) begin
            if (q == 2'd1) begin
              state_d = S_LOCK; pat_d = PAT_BF; step_d = 3'd1; stb_d = 1'b1;
            end else if (q == 2'd3) begin
              state_d = S_LOCK; pat_d = PAT_RIGHT; step_d = 3'd0; stb_d = 1'b1;
            end
          end else if (q == (dir_up_q ? pos_q + 2'd1 : pos_q - 2'd1)) state_d = S_DIR;
        end else if (stall) begin
          state_d = S_ACQ;
          pos_d   = q;
        end
      end
      S_LOCK: begin
        if (change) begin
          if (valid && q == npos) begin
            pos_d  = npos;
            step_d = nstep;
            stb_d  = 1'b1;
          end else begin
            err_d   = 1'b1;
            pos_d   = q;
            state_d = valid ? S_ACQ : S_EMPTY;
          end
        end else if (stall) begin
          err_d   = 1'b1;
          pos_d   = q;
          state_d = S_ACQ;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_EMPTY;
      led_s    <= '0;
      led_p    <= '0;
      pos_q    <= '0;
      dir_up_q <= 1'b0;
      pat_q    <= PAT_NONE;
      step_q   <= '0;
      tmr_q    <= '0;
      stb_q    <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      led_s    <= bus.LED;
      led_p    <= led_s;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      pat_q    <= pat_d;
      step_q   <= step_d;
      tmr_q    <= tmr_d;
      stb_q    <= stb_d;
      err_q    <= err_d;
      // A clear in the same cycle as an error wins, although ERR still pulses.
      if (bus.CLR)                       cnt_q <= '0;
      else if (err_d && cnt_q != 8'hFF) cnt_q <= cnt_q + 8'd1;
    end
  end

  assign bus.PATTERN   = (state_q == S_LOCK) ? pat_q : PAT_NONE;
  assign bus.STEP      = (state_q == S_LOCK) ? step_q : 3'd0;
  assign bus.LOCKED    = (state_q == S_LOCK);
  assign bus.STEP_STB  = stb_q;
  assign bus.ERR       = err_q;
  assign bus.ERR_CNT   = cnt_q;
  assign bus.DBG_STATE = state_q;
endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench for led_pattern_decoder. Each LED step queues the decoder's expected response.
// That response is popped and compared two edges later.
module tb_led_pattern_decoder;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  led_pattern_decoder_if bus();

  led_pattern_decoder #(.TIMEOUT(16), .TW(25)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mask_q[$];

  // Observed vector: {PATTERN, STEP, LOCKED, STEP_STB, ERR, ERR_CNT}
  function automatic logic [15:0] obs();
    return {bus.PATTERN, bus.STEP, bus.LOCKED, bus.STEP_STB, bus.ERR, bus.ERR_CNT};
  endfunction

  task automatic check(input string tag, input logic [15:0] o, input logic [15:0] e,
                       input logic [15:0] m);
    checks++;
    assert ((o & m) === (e & m))
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o & m, e & m);
    end
  endtask

  task automatic push_exp(input logic [1:0] pat, input logic [2:0] stp, input logic lk,
                          input logic stb, input logic err, input logic stb_care);
    exp_q.push_back({pat, stp, lk, stb, err, exp_cnt[7:0]});
    mask_q.push_back(stb_care ? 16'hFFFF : 16'hFDFF);
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e, m;
    e = exp_q.pop_front();
    m = mask_q.pop_front();
    check(tag, obs(), e, m);
  endtask

  task automatic bump_cnt();
    exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
  endtask

  // Called at a negedge. It drives LED, samples two edges later and checks.
  // It then checks that the strobes stay low until the next 4-cycle step.
  task automatic drive_step(input string tag, input logic [3:0] v, input logic [1:0] pat,
                            input logic [2:0] stp, input logic lk, input logic stb,
                            input logic err, input logic stb_care);
    bus.LED = v;
    if (err) bump_cnt();
    push_exp(pat, stp, lk, stb, err, stb_care);
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    pop_check(tag);
    repeat (2) begin
      @(negedge CLK);
      check({tag, "_idle"}, obs(), 16'h0000, 16'h0300);
    end
  endtask

  task automatic acq(input string tag, input logic [3:0] v);
    drive_step(tag, v, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Holds LED and waits (bounded) for the stall ERR pulse while locked.
  task automatic wait_stall(input string tag, input logic clr);
    int n;
    n = 0;
    bus.CLR = clr;
    while (bus.ERR !== 1'b1 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (clr) exp_cnt = 0;
    else bump_cnt();
    push_exp(2'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    pop_check(tag);
    bus.CLR = 1'b0;
    checks++;
    assert (n >= 10 && n <= 30)
    else begin
      failures++;
      $error("FAIL %s_latency observed=%0d expected=10..30", tag, n);
    end
    @(negedge CLK);
    check({tag, "_pulse"}, obs(), 16'h0000, 16'h0300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST     = 1'b0;
    bus.LED = 4'b0000;
    bus.CLR = 1'b0;
    repeat (3) @(negedge CLK);
    push_exp(2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("reset");
    RST = 1'b1;
    @(negedge CLK);

    // Left lock, then a jump violation and a relock.
    acq("t1_a", 4'b0001); acq("t1_b", 4'b0010); acq("t1_c", 4'b0100); acq("t1_d", 4'b1000);
    drive_step("t1_lock",  4'b0001, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t1_step1", 4'b0010, 2'd1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t1_step2", 4'b0100, 2'd1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t1_step3", 4'b1000, 2'd1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t1_step0", 4'b0001, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t4_jump",  4'b0100, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    acq("t4_dir", 4'b1000);
    drive_step("t4_relock", 4'b0001, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Stall while locked, then relock and stall again with CLR held.
    wait_stall("t5_stall", 1'b0);
    acq("t5_a", 4'b0010); acq("t5_b", 4'b0100); acq("t5_c", 4'b1000);
    drive_step("t5_relock", 4'b0001, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_stall("t5_clr", 1'b1);

    // An invalid value while locked drops to EMPTY; a zero LED then stays quiet.
    acq("t6_a", 4'b0010); acq("t6_b", 4'b0100); acq("t6_c", 4'b1000);
    drive_step("t6_lock",    4'b0001, 2'd1, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t6_invalid", 4'b0011, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive_step("t6_zero",    4'b0000, 2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (24) begin
      @(negedge CLK);
      check("t6_quiet", obs(), {2'd3, 3'd0, 3'b000, exp_cnt[7:0]}, 16'hFFFF);
    end

    // Right lock.
    acq("t3_a", 4'b1000); acq("t3_b", 4'b0100); acq("t3_c", 4'b0010); acq("t3_d", 4'b0001);
    drive_step("t3_lock",  4'b1000, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t3_step1", 4'b0100, 2'd2, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t3_step2", 4'b0010, 2'd2, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t3_step3", 4'b0001, 2'd2, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t3_step0", 4'b1000, 2'd2, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset while locked, sampled away from any clock edge.
    RST = 1'b0;
    #2;
    exp_cnt = 0;
    push_exp(2'd3, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    pop_check("t6_async_reset");
    bus.LED = 4'b0000;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Back-and-forth locked at the top reversal, running through a full cycle.
    acq("t2_a", 4'b0001); acq("t2_b", 4'b0010); acq("t2_c", 4'b0100); acq("t2_d", 4'b1000);
    drive_step("t2_lock",  4'b0100, 2'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step5", 4'b0010, 2'd0, 3'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step0", 4'b0001, 2'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step1", 4'b0010, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step2", 4'b0100, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step3", 4'b1000, 2'd0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("t2_step4", 4'b0100, 2'd0, 3'd4, 1'b1, 1'b1, 1'b0, 1'b1);

    // Back-and-forth locked at the bottom reversal.
    drive_step("bf_drop", 4'b0000, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    acq("bf_a", 4'b1000); acq("bf_b", 4'b0100); acq("bf_c", 4'b0010); acq("bf_d", 4'b0001);
    drive_step("bf_lock_bot", 4'b0010, 2'd0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1);
    drive_step("bf_step2",    4'b0100, 2'd0, 3'd2, 1'b1, 1'b1, 1'b0, 1'b1);

    // Error count saturation: each lock-then-jump triple is exactly one error.
    drive_step("sat_drop", 4'b0000, 2'd3, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      bus.LED = 4'b1000; @(negedge CLK);
      bus.LED = 4'b0001; @(negedge CLK);
      bus.LED = 4'b0100; @(negedge CLK);
      bump_cnt();
    end
    repeat (3) @(negedge CLK);
    check("sat_mid", obs(), {2'd3, 3'd0, 3'b000, exp_cnt[7:0]}, 16'hFFFF);
    for (int i = 0; i < 200; i++) begin
      bus.LED = 4'b1000; @(negedge CLK);
      bus.LED = 4'b0001; @(negedge CLK);
      bus.LED = 4'b0100; @(negedge CLK);
      bump_cnt();
    end
    repeat (3) @(negedge CLK);
    check("sat_255", obs(), {2'd3, 3'd0, 3'b000, 8'hFF}, 16'hFFFF);
    check("sat_model", obs(), {2'd3, 3'd0, 3'b000, exp_cnt[7:0]}, 16'h00FF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
